// File: rtl/line_win_scanner.sv
// Connect-four win detector: sweeps every WIN_LEN window through the dropped
// piece, one board read per cycle. Define LINE_WIN_WRITEBACK_EN to enable winning-cell writeback.
module line_win_scanner #(
  parameter int ROWS    = 6,
  parameter int COLS    = 7,
  parameter int WIN_LEN = 4,
  parameter int RW      = 3,
  parameter int CW      = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [RW-1:0] row,
  input  logic [CW-1:0] col,
  input  logic [1:0]    data_in,
  output logic [RW-1:0] read_row,
  output logic [CW-1:0] read_col,
  output logic          busy,
  output logic          done,
  output logic [1:0]    winner,
  output logic [1:0]    win_dir,
  output logic          wr_en,
  output logic [RW-1:0] wr_row,
  output logic [CW-1:0] wr_col
);

  // state  | meaning
  // IDLE   | waiting for start
  // REF    | origin cell on data_in, captured as reference player
  // SELECT | test current window against board bounds
  // READ   | compare window cell k against reference
  // WRITE  | stream winning cells on wr_* (writeback builds only)
  // DONE   | one-cycle done pulse
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REF    = 3'd1;
  localparam logic [2:0] S_SELECT = 3'd2;
  localparam logic [2:0] S_READ   = 3'd3;
`ifdef LINE_WIN_WRITEBACK_EN
  localparam logic [2:0] S_WRITE  = 3'd4;
`endif
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam int JW = $clog2(WIN_LEN);
  localparam logic [JW-1:0]        LAST_IDX = JW'(WIN_LEN - 1);
  localparam logic signed [RW+1:0] WM1_R    = (RW+2)'(WIN_LEN - 1);
  localparam logic signed [CW+1:0] WM1_C    = (CW+2)'(WIN_LEN - 1);
  localparam logic signed [RW+1:0] ROWS_S   = (RW+2)'(ROWS);
  localparam logic signed [CW+1:0] COLS_S   = (CW+2)'(COLS);
  localparam logic [RW:0]          ROWS_U   = (RW+1)'(ROWS);
  localparam logic [CW:0]          COLS_U   = (CW+1)'(COLS);

  logic [2:0]           state;
  logic [RW-1:0]        row_q;
  logic [CW-1:0]        col_q;
  logic [1:0]           ref_q;
  logic [1:0]           dir_q;
  logic [JW-1:0]        j_q;
  logic [JW-1:0]        k_q;
  logic signed [RW+1:0] cur_r;
  logic signed [CW+1:0] cur_c;
  logic [1:0]           winner_q;
  logic [1:0]           win_dir_q;

  logic signed [RW+1:0] row_s, pos_r, off_r, r0, r1, dr_s;
  logic signed [CW+1:0] col_s, pos_c, off_c, c0, c1, dc_s;
  logic                 win_valid, is_last, last_k, origin_oob;
  logic [1:0]           nxt_dir;
  logic [JW-1:0]        nxt_j;

  // Window j of direction d spans offsets (j-(WIN_LEN-1)) .. j along the step
  // vector; the line is straight, so checking both end cells bounds the window.
  always_comb begin
    row_s = {2'b00, row_q};
    col_s = {2'b00, col_q};
    pos_r = (RW+2)'(j_q);
    pos_c = (CW+2)'(j_q);
    off_r = pos_r - WM1_R;
    off_c = pos_c - WM1_C;
    r0    = row_s;
    r1    = row_s;
    c0    = col_s;
    c1    = col_s;
    dr_s  = '0;
    dc_s  = '0;
    case (dir_q)
      2'd0, 2'd2: begin
        r0   = row_s + off_r;
        r1   = row_s + pos_r;
        dr_s = (RW+2)'(1);
      end
      2'd3: begin
        r0   = row_s - off_r;
        r1   = row_s - pos_r;
        dr_s = '1;
      end
      default: ;
    endcase
    if (dir_q != 2'd0) begin
      c0   = col_s + off_c;
      c1   = col_s + pos_c;
      dc_s = (CW+2)'(1);
    end
    win_valid = !r0[RW+1] && (r0 < ROWS_S) && !r1[RW+1] && (r1 < ROWS_S) &&
                !c0[CW+1] && (c0 < COLS_S) && !c1[CW+1] && (c1 < COLS_S);
    is_last   = (dir_q == 2'd3) && (j_q == LAST_IDX);
    last_k    = (k_q == LAST_IDX);
    // Vertical has a single window (origin at the top), so it advances straight to d1.
    if (dir_q == 2'd0) begin
      nxt_dir = 2'd1;
      nxt_j   = '0;
    end else if (j_q == LAST_IDX) begin
      nxt_dir = dir_q + 2'd1;
      nxt_j   = '0;
    end else begin
      nxt_dir = dir_q;
      nxt_j   = j_q + JW'(1);
    end
    origin_oob = ({1'b0, row} >= ROWS_U) || ({1'b0, col} >= COLS_U);
  end

`ifdef LINE_WIN_WRITEBACK_EN
  logic signed [RW+1:0] wr_r;
  logic signed [CW+1:0] wr_c;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      ref_q     <= '0;
      dir_q     <= '0;
      j_q       <= '0;
      k_q       <= '0;
      cur_r     <= '0;
      cur_c     <= '0;
      winner_q  <= '0;
      win_dir_q <= '0;
`ifdef LINE_WIN_WRITEBACK_EN
      wr_r      <= '0;
      wr_c      <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            row_q     <= row;
            col_q     <= col;
            winner_q  <= '0;
            win_dir_q <= '0;
            if (origin_oob) begin
              state <= S_DONE;
            end else begin
              cur_r <= {2'b00, row};
              cur_c <= {2'b00, col};
              state <= S_REF;
            end
          end
        end
        S_REF: begin
          ref_q <= data_in;
          dir_q <= '0;
          j_q   <= '0;
          state <= (data_in == 2'd0) ? S_DONE : S_SELECT;
        end
        S_SELECT: begin
          if (win_valid) begin
            cur_r <= r0;
            cur_c <= c0;
            k_q   <= '0;
            state <= S_READ;
          end else if (is_last) begin
            state <= S_DONE;
          end else begin
            dir_q <= nxt_dir;
            j_q   <= nxt_j;
          end
        end
        S_READ: begin
          if (data_in != ref_q) begin
            if (is_last) begin
              state <= S_DONE;
            end else begin
              dir_q <= nxt_dir;
              j_q   <= nxt_j;
              state <= S_SELECT;
            end
          end else if (last_k) begin
            winner_q  <= ref_q;
            win_dir_q <= dir_q;
`ifdef LINE_WIN_WRITEBACK_EN
            wr_r  <= r0;
            wr_c  <= c0;
            k_q   <= '0;
            state <= S_WRITE;
`else
            state <= S_DONE;
`endif
          end else begin
            k_q   <= k_q + JW'(1);
            cur_r <= cur_r + dr_s;
            cur_c <= cur_c + dc_s;
          end
        end
`ifdef LINE_WIN_WRITEBACK_EN
        S_WRITE: begin
          if (last_k) begin
            state <= S_DONE;
          end else begin
            k_q  <= k_q + JW'(1);
            wr_r <= wr_r + dr_s;
            wr_c <= wr_c + dc_s;
          end
        end
`endif
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign read_row = cur_r[RW-1:0];
  assign read_col = cur_c[CW-1:0];
  assign busy     = (state != S_IDLE) && (state != S_DONE);
  assign done     = (state == S_DONE);
  assign winner   = winner_q;
  assign win_dir  = win_dir_q;
`ifdef LINE_WIN_WRITEBACK_EN
  assign wr_en    = (state == S_WRITE);
  assign wr_row   = wr_r[RW-1:0];
  assign wr_col   = wr_c[CW-1:0];
`else
  assign wr_en    = 1'b0;
  assign wr_row   = '0;
  assign wr_col   = '0;
`endif

endmodule
